// File: rtl/iterative_subtractor_64.sv
`default_nettype none
// ============================================================================
// Module      : iterative_subtractor_64
// Description : Multi-cycle unsigned subtractor, DIFF = A - B, CHUNK bits per
//               clock LSB chunk first, with START/BUSY/DONE handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_subtractor_64 #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o,
   output logic             zero_o
);

   localparam int N  = WIDTH / CHUNK;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(N - 1);

   generate
      if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
         $error("iterative_subtractor_64: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             brw_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             borrow_q;
   logic             zero_q;

   logic [CHUNK:0]   sub_d;
   logic [WIDTH-1:0] res_d;

   // Operands shift right each RUN cycle so the active chunk is always the low
   // CHUNK bits; the result fills from the top and is complete after N shifts.
   assign sub_d = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]}
                - {{CHUNK{1'b0}}, brw_q};
   assign res_d = (res_q >> CHUNK) | (WIDTH'(sub_d[CHUNK-1:0]) << (WIDTH - CHUNK));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         brw_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  a_q     <= a_i;
                  b_q     <= b_i;
                  brw_q   <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               a_q   <= a_q >> CHUNK;
               b_q   <= b_q >> CHUNK;
               res_q <= res_d;
               brw_q <= sub_d[CHUNK];
               if (cnt_q == C_LAST) begin
                  diff_q   <= res_d;
                  borrow_q <= sub_d[CHUNK];
                  zero_q   <= (res_d == '0);
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign diff_o   = diff_q;
   assign borrow_o = borrow_q;
   assign zero_o   = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_iterative_subtractor_64.sv
`default_nettype none
// ============================================================================
// Module      : tb_iterative_subtractor_64
// Description : Scoreboard bench for iterative_subtractor_64 with an
//               arithmetic reference model and a cycle-level handshake model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_subtractor_64;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [63:0] a_in;
   logic [63:0] b_in;
   logic        busy;
   logic        done;
   logic [63:0] diff;
   logic        borrow;
   logic        zero;

   iterative_subtractor_64 #(.WIDTH(64), .CHUNK(16)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .a_i     (a_in),
      .b_i     (b_in),
      .busy_o  (busy),
      .done_o  (done),
      .diff_o  (diff),
      .borrow_o(borrow),
      .zero_o  (zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] diff;
      logic        brw;
      logic        zero;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          cyc      = 0;
   int          last_acc = -100;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, expv);
      end
   endtask

   // Reference: plain modular arithmetic on the operands.
   task automatic push_exp(input logic [63:0] a, input logic [63:0] b, input int acc);
      exp_t e;
      e.diff = a - b;
      e.brw  = (a < b);
      e.zero = (a == b);
      e.acc  = acc;
      sb.push_back(e);
   endtask

   // Called on a negedge; returns on the negedge after the accepting edge.
   task automatic issue(input logic [63:0] a, input logic [63:0] b);
      while (cyc + 1 - last_acc < N + 1) @(negedge clk);
      start = 1'b1;
      a_in  = a;
      b_in  = b;
      push_exp(a, b, cyc + 1);
      last_acc = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      a_in  = {$urandom, $urandom};
      b_in  = {$urandom, $urandom};
   endtask

   task automatic wait_idle();
      int k = 0;
      while (sb.size() != 0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   // Monitor: handshake model plus held-output model, checked every cycle.
   logic        r_s;
   logic        e_done;
   logic        e_busy;
   logic [63:0] e_diff = '0;
   logic        e_brw  = 1'b0;
   logic        e_zero = 1'b0;
   exp_t        e_pop;

   always @(posedge clk) begin
      cyc++;
      r_s = rst;
      #1;
      if (r_s) begin
         e_done = 1'b0;
         e_busy = 1'b0;
         e_diff = '0;
         e_brw  = 1'b0;
         e_zero = 1'b0;
      end else begin
         e_busy = (cyc >= last_acc) && (cyc < last_acc + N);
         e_done = (sb.size() > 0) && (sb[0].acc + N == cyc);
         if (e_done) begin
            e_pop  = sb.pop_front();
            e_diff = e_pop.diff;
            e_brw  = e_pop.brw;
            e_zero = e_pop.zero;
         end
      end
      chk("done",   64'(done),   64'(e_done));
      chk("busy",   64'(busy),   64'(e_busy));
      chk("diff",   diff,        e_diff);
      chk("borrow", 64'(borrow), 64'(e_brw));
      chk("zero",   64'(zero),   64'(e_zero));
   end

   initial begin
      rst   = 1'b1;
      start = 1'b1;
      a_in  = 64'd7;
      b_in  = 64'd1;
      repeat (3) @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;

      // Basic op and fixed-value spot checks
      issue(64'd5, 64'd3);
      wait_idle();
      chk("t1_diff", diff, 64'd2);
      chk("t1_borrow", 64'(borrow), 64'd0);
      issue(64'd3, 64'd5);
      issue(64'd0, 64'd1);
      wait_idle();
      chk("t2_wrap", diff, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t2_borrow", 64'(borrow), 64'd1);
      issue(64'h0001_0000_0000_0000, 64'd1);
      wait_idle();
      chk("t3_xchunk", diff, 64'h0000_FFFF_FFFF_FFFF);
      issue(64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
      wait_idle();
      chk("t3_zero", 64'(zero), 64'd1);

      // START held with changing operands: only idle-cycle edges accept
      for (int i = 0; i < 10; i++) begin
         start = 1'b1;
         a_in  = {$urandom, $urandom};
         b_in  = {$urandom, $urandom};
         if (cyc + 1 - last_acc >= N + 1) begin
            push_exp(a_in, b_in, cyc + 1);
            last_acc = cyc + 1;
         end
         @(negedge clk);
      end
      start = 1'b0;
      wait_idle();

      // Abort mid-operation
      issue(64'd9, 64'd4);
      rst = 1'b1;
      sb.delete();
      last_acc = -100;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_diff", diff, 64'd0);
      issue(64'd9, 64'd4);
      wait_idle();
      chk("after_abort", diff, 64'd5);

      for (int a = 0; a <= 32; a++)
         for (int b = 0; b <= 32; b++)
            issue(64'(a), 64'(b));
      for (int i = 0; i < 1000; i++)
         issue({$urandom, $urandom}, {$urandom, $urandom});
      wait_idle();
      repeat (N + 2) @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
